// File: rtl/d8m_crop_writer.sv
// D8M crop writer: crops a fixed H/V window from the raw 12-bit sensor stream into the SDRAM write FIFO.
// Optional build macro D8M_CROP_TPG_EN replaces pixel data with a window-coordinate test pattern.
`timescale 1ns/1ps
module d8m_crop_writer #(
  parameter int unsigned H_START  = 0,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_START  = 0,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iFIFO_AFULL,
  output logic        oWR_EN,
  output logic [15:0] oWR_DATA,
  output logic        oSOF,
  output logic        oEOF,
  output logic        oFRAME_DROP,
  output logic [15:0] oFRAME_CNT
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DROP} state_t;

  localparam logic [17:0] H_LO  = 18'(H_START);
  localparam logic [17:0] H_LEN = 18'(H_ACTIVE);
  localparam logic [17:0] V_LO  = 18'(V_START);
  localparam logic [17:0] V_LEN = 18'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        pre_fval_q, pre_lval_q;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        wr_en_q, wr_en_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        drop_q, drop_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        fval_rise, fval_fall, lval_fall;
  logic        pix_valid, cap_en, in_win, win_first, win_last;
  logic [15:0] y_cur;
  logic [17:0] dx, dy;

  assign fval_rise = !pre_fval_q && iFVAL;
  assign fval_fall = pre_fval_q && !iFVAL;
  assign lval_fall = pre_lval_q && !iLVAL;
  assign pix_valid = iFVAL && iLVAL;

  // y is cleared on the FVAL rise edge itself; use the cleared value for a pixel arriving that cycle.
  assign y_cur = fval_rise ? '0 : y_q;

  // Window-relative offsets; positions left of/above the window wrap to large values and fail the < test.
  assign dx = {2'b00, x_q} - H_LO;
  assign dy = {2'b00, y_cur} - V_LO;

  assign in_win    = (dx < H_LEN) && (dy < V_LEN);
  assign win_first = (dx == '0) && (dy == '0);
  assign win_last  = (dx == H_LEN - 18'd1) && (dy == V_LEN - 18'd1);

  // A pixel coinciding with the FVAL rise belongs to the frame being accepted.
  assign cap_en = (state_q == CAPTURE) ||
                  ((state_q == ARMED) && fval_rise && !iFIFO_AFULL);

  always_comb begin
    state_d = state_q;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!iFVAL) state_d = ARMED;
      end
      ARMED: begin
        if (fval_rise) begin
          if (iFIFO_AFULL) begin
            state_d = DROP;
            drop_d  = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE, DROP: begin
        if (fval_fall) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = cap_en && pix_valid && in_win;
    sof_d     = wr_en_d && win_first;
    eof_d     = wr_en_d && win_last;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
`ifdef D8M_CROP_TPG_EN
      wr_data_d = {4'b0000, dx[5:0], dy[5:0]};
`else
      wr_data_d = {4'b0000, iDATA};
`endif
    end

    frame_cnt_d = frame_cnt_q;
    if (eof_d) frame_cnt_d = frame_cnt_q + 16'd1;

    x_d = x_q;
    if (lval_fall) begin
      x_d = '0;
    end else if (iLVAL && (x_q != '1)) begin
      x_d = x_q + 16'd1;
    end

    y_d = y_q;
    if (fval_rise) begin
      y_d = '0;
    end else if (lval_fall && iFVAL && (y_q != '1)) begin
      y_d = y_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= IDLE;
      pre_fval_q  <= iFVAL;
      pre_lval_q  <= iLVAL;
      x_q         <= '0;
      y_q         <= '0;
      wr_en_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      drop_q      <= 1'b0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_fval_q  <= iFVAL;
      pre_lval_q  <= iLVAL;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_en_q     <= wr_en_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      drop_q      <= drop_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign oWR_EN      = wr_en_q;
  assign oWR_DATA    = wr_data_q;
  assign oSOF        = sof_q;
  assign oEOF        = eof_q;
  assign oFRAME_DROP = drop_q;
  assign oFRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_d8m_crop_writer.sv
// Self-checking bench for d8m_crop_writer: directed frames plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_d8m_crop_writer;

  localparam int H_START  = 2;
  localparam int H_ACTIVE = 4;
  localparam int V_START  = 1;
  localparam int V_ACTIVE = 2;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iFIFO_AFULL;
  logic        oWR_EN;
  logic [15:0] oWR_DATA;
  logic        oSOF;
  logic        oEOF;
  logic        oFRAME_DROP;
  logic [15:0] oFRAME_CNT;

  d8m_crop_writer #(
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDATA      (iDATA),
    .iFVAL      (iFVAL),
    .iLVAL      (iLVAL),
    .iFIFO_AFULL(iFIFO_AFULL),
    .oWR_EN     (oWR_EN),
    .oWR_DATA   (oWR_DATA),
    .oSOF       (oSOF),
    .oEOF       (oEOF),
    .oFRAME_DROP(oFRAME_DROP),
    .oFRAME_CNT (oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Observed writes as {sof, eof, data}, collected mid-cycle.
  logic [17:0] got_q[$];
  int          drop_seen = 0;

  always @(negedge iCLK) begin
    if (oWR_EN === 1'b1) got_q.push_back({oSOF, oEOF, oWR_DATA});
    if (oFRAME_DROP === 1'b1) drop_seen++;
  end

  // Model state
  bit armed;
  int fcnt_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {31'd0, oWR_EN}, 32'd0);
    check({tag, "_data"},  {16'd0, oWR_DATA}, 32'd0);
    check({tag, "_sof"},   {31'd0, oSOF}, 32'd0);
    check({tag, "_eof"},   {31'd0, oEOF}, 32'd0);
    check({tag, "_drop"},  {31'd0, oFRAME_DROP}, 32'd0);
    check({tag, "_cnt"},   {16'd0, oFRAME_CNT}, 32'd0);
  endtask

  // Drives one frame. npx=0 gives a random length per line; pat selects data 0x100+x.
  // rst_px >= 0 pulls reset low right after the pixel with that frame-global index is registered.
  task automatic run_frame(input string tag, input int nlines, input int npx,
                           input bit afull_rise, input bit afull_mid, input bit pat,
                           input int rst_px);
    logic [17:0] exp_q[$];
    logic [11:0] d;
    logic [15:0] edata;
    int          g, len, blank, drops_exp, nmin;
    bit          cap, win, first, last;

    cap       = armed && !afull_rise;
    drops_exp = (armed && afull_rise) ? 1 : 0;
    got_q.delete();
    drop_seen = 0;

    @(posedge iCLK); #1;
    iFVAL = 1'b1;
    iFIFO_AFULL = afull_rise;
    @(posedge iCLK); #1;
    iFIFO_AFULL = afull_mid;

    g = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (npx > 0) ? npx : int'($urandom_range(9, 1));
      for (int p = 0; p < len; p++) begin
        d = pat ? 12'(12'h100 + p) : 12'($urandom);
        win   = (p >= H_START) && (p < H_START + H_ACTIVE) &&
                (l >= V_START) && (l < V_START + V_ACTIVE);
        first = (p == H_START) && (l == V_START);
        last  = (p == H_START + H_ACTIVE - 1) && (l == V_START + V_ACTIVE - 1);
`ifdef D8M_CROP_TPG_EN
        edata = {4'b0000, 6'(p - H_START), 6'(l - V_START)};
`else
        edata = {4'b0000, d};
`endif
        iLVAL = 1'b1;
        iDATA = d;
        if (cap && win && (g != rst_px)) begin
          exp_q.push_back({first, last, edata});
          if (last) fcnt_model = (fcnt_model + 1) & 16'hFFFF;
        end
        @(posedge iCLK); #1;
        if (g == rst_px) begin
          if (cap && win) check({tag, "_wr_before_rst"}, {31'd0, oWR_EN}, 32'd1);
          iRST = 1'b0;
          #1;
          check_reset_outputs({tag, "_async_rst"});
          cap        = 1'b0;
          armed      = 1'b0;
          fcnt_model = 0;
        end
        if (g == rst_px + 2) iRST = 1'b1;
        g++;
      end
      iLVAL = 1'b0;
      blank = int'($urandom_range(4, 2));
      repeat (blank) @(posedge iCLK);
      #1;
    end

    iFVAL = 1'b0;
    iFIFO_AFULL = 1'b0;
    armed = 1'b1;
    repeat (4) @(posedge iCLK);
    #1;

    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("%s_wr%0d", tag, i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
    end
    check({tag, "_drops"}, drop_seen, drops_exp);
    check({tag, "_frame_cnt"}, {16'd0, oFRAME_CNT}, fcnt_model);
  endtask

  initial begin
    iRST        = 1'b0;
    iDATA       = '0;
    iFVAL       = 1'b0;
    iLVAL       = 1'b0;
    iFIFO_AFULL = 1'b0;
    armed       = 1'b0;
    fcnt_model  = 0;

    repeat (3) @(posedge iCLK);
    #1;
    check_reset_outputs("reset");
    iRST = 1'b1;
    armed = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;

    // Basic crop of a 3-line, 8-pixel frame.
    run_frame("s1", 3, 8, 1'b0, 1'b0, 1'b1, -1);

    // Reset pulse early in a frame: rest of that frame ignored, then clean capture.
    run_frame("s2_rst", 3, 8, 1'b0, 1'b0, 1'b1, 1);
    run_frame("s2_next", 3, 8, 1'b0, 1'b0, 1'b1, -1);

    // Almost-full at frame start drops the frame; mid-frame almost-full is ignored.
    run_frame("s3_drop", 3, 8, 1'b1, 1'b0, 1'b1, -1);
    run_frame("s3_mid", 3, 8, 1'b0, 1'b1, 1'b1, -1);

    // Short frame: SOF but no EOF.
    run_frame("s4_short", 2, 8, 1'b0, 1'b0, 1'b1, -1);

    // Reset during the third write, then a fresh frame restarts the count.
    run_frame("s5_rst", 3, 8, 1'b0, 1'b0, 1'b1, 12);
    run_frame("s5_next", 3, 8, 1'b0, 1'b0, 1'b1, -1);

    // Short lines, window extending past the line end.
    run_frame("s6_narrow", 3, 4, 1'b0, 1'b0, 1'b1, -1);

    // Randomized frames: random heights, ragged line lengths, random data and FIFO pressure.
    for (int f = 0; f < 16; f++) begin
      run_frame($sformatf("rnd%0d", f), int'($urandom_range(4, 1)), 0,
                ($urandom_range(4, 0) == 0), bit'($urandom_range(1, 0)), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d8m_crop_writer.md
Name: d8m_crop_writer

Overview:
- Sits directly downstream of the D8M capture/counter stage.
- Consumes the raw 12-bit sensor stream qualified by FVAL/LVAL and crops a fixed window out of each frame.
- Emits write strobes and zero-extended 16-bit words into the SDRAM write FIFO, with frame start/end markers.
- Drops whole frames when the FIFO is near full at frame start, so SDRAM never holds a torn frame.

Parameters:
- H_START, 0, first captured pixel index within a line.
- H_ACTIVE, 640, captured pixels per line (>=1).
- V_START, 0, first captured line index within a frame.
- V_ACTIVE, 480, captured lines per frame (>=1).

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-low reset.
- iDATA  in  12  raw pixel, valid when iFVAL&iLVAL.
- iFVAL  in  1  frame valid.
- iLVAL  in  1  line valid.
- iFIFO_AFULL  in  1  downstream FIFO almost-full.
- oWR_EN  out  1  FIFO write strobe.
- oWR_DATA  out  16  {4'b0, pixel}.
- oSOF  out  1  high with first write of a frame.
- oEOF  out  1  high with last write of a frame.
- oFRAME_DROP  out  1  one-cycle pulse, frame skipped.
- oFRAME_CNT  out  16  completed frames, wraps at 16'hFFFF->0.

Behaviour:
- Reset is asynchronous, active-low on iRST; clock is iCLK.
- Reset values: all outputs 0; state IDLE; x/y counters 0; Pre_FVAL/Pre_LVAL sample inputs.
- Edge detect: registered Pre_FVAL/Pre_LVAL; rise = !pre & cur, fall = pre & !cur.
- x counter: increments each cycle iLVAL=1; cleared on LVAL fall; saturates at 16'hFFFF.
- y counter: increments on LVAL fall while iFVAL=1; cleared on FVAL rise; saturates at 16'hFFFF.
- Window condition: H_START <= x < H_START+H_ACTIVE and V_START <= y < V_START+V_ACTIVE, evaluated on the current-cycle x/y with iFVAL&iLVAL. Compare in 17 bits so no overflow.
- Latency: one cycle. oWR_EN and oWR_DATA are registered from the qualifying input cycle.
- State IDLE: entered after reset. Go to ARMED when iFVAL=0 (never capture a partial frame after reset).
- State ARMED, on FVAL rise:
  - iFIFO_AFULL=1 -> DROP, with oFRAME_DROP pulsed on the following cycle.
  - else -> CAPTURE.
- State CAPTURE:
  - Writes enabled for window pixels.
  - iFIFO_AFULL is ignored mid-frame.
  - FVAL fall -> ARMED.
- State DROP: no writes. FVAL fall -> ARMED.
- Simultaneous FVAL fall and rise cannot occur. If FVAL falls and a new FVAL rise arrives on the next cycle, ARMED handles it normally.
- oSOF: set with the write at x=H_START, y=V_START; one cycle.
- oEOF: set with the write at x=H_START+H_ACTIVE-1, y=V_START+V_ACTIVE-1; one cycle. oFRAME_CNT increments on the same edge.
- Short frame (FVAL falls before the last window pixel): no oEOF, oFRAME_CNT unchanged.
- Short line (LVAL falls early): only the pixels present are written, with no padding.
- Window beyond the sensor extent: window pixels that never arrive are never written.
- iRST low mid-frame: outputs clear immediately; after release the remainder of the current frame is ignored (IDLE waits for FVAL=0).

Optional Feature:
- Macro: D8M_CROP_TPG_EN.
- When defined: oWR_DATA carries a test pattern instead of iDATA, {4'b0, x[5:0], y[5:0]} using the window-relative x/y of the written pixel. Timing, strobes and drop logic are identical.
- When undefined: oWR_DATA = {4'b0, iDATA}, and no pattern logic is synthesised.

Test Plan:
1. H_START=2,H_ACTIVE=4,V_START=1,V_ACTIVE=2; release reset with FVAL=0; send a 3-line frame, 8 px/line, iDATA=12'h100+x -> writes per captured line carry data 0x102..0x105, on lines y=1,2 only (8 writes total); oSOF with first, oEOF with eighth; oFRAME_CNT=1.
2. Release reset while FVAL=1 mid-frame -> zero writes until the next FVAL rise; next full frame yields 8 writes.
3. iFIFO_AFULL=1 at FVAL rise -> zero writes, one oFRAME_DROP pulse, oFRAME_CNT unchanged. iFIFO_AFULL raised mid-frame in CAPTURE -> all 8 writes still occur.
4. Frame of only 2 lines (y=0,1) -> 4 writes, oSOF high, no oEOF, oFRAME_CNT unchanged.
5. Assert iRST low during the 3rd write -> oWR_EN=0 the same cycle; following frame captures cleanly, with oFRAME_CNT restarting at 1.
6. With D8M_CROP_TPG_EN defined, repeat scenario 1 -> data sequence 0x000,0x040,0x080,0x0C0,0x001,0x041,0x081,0x0C1.
